// File: rtl/pathfinding_pkg.sv
// Shared types and defaults for the pathfinding explored-set RAM and its clients.
package pathfinding_pkg;

    localparam int          NODE_INFO_W       = 272;
    localparam int          MAX_NODES_DEFAULT = 100;
    localparam int          ADDR_W_DEFAULT    = 7;
    localparam logic [15:0] NODE_ID_EMPTY     = 16'd0;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } map_node;

    // One explored-set record; node_id 0 marks an empty slot.
    typedef struct packed {
        logic [15:0]  node_id;
        logic [15:0]  parent_id;
        map_node      position;
        logic [31:0]  cost;
        logic [31:0]  heuristic;
        logic [143:0] reserved;
    } node_info;

    typedef enum logic [1:0] {
        APPENDED = 2'b00,
        UPDATED  = 2'b01,
        FULL     = 2'b10,
        INVALID  = 2'b11
    } write_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN_SET,
        S_SCAN_WAIT,
        S_SCAN_READ,
        S_WRITE,
        S_DONE
    } writer_state_t;

endpackage

// File: rtl/explored_writer.sv
// Write side of the explored-set RAM: clear sweep, and insert by scan-then-update-or-append.
// Owns the fill count; the read port is shared with the search readers while busy is low.
import pathfinding_pkg::*;

module explored_writer #(
    parameter int MAX_NODES = MAX_NODES_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              insert,
    input  node_info          new_node,
    input  node_info          read_node,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output node_info          write_data,
    output logic [ADDR_W-1:0] read_address,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [ADDR_W-1:0] slot_address,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_NODES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(MAX_NODES);

    writer_state_t     state_q, state_d;
    logic [ADDR_W-1:0] write_address_q, write_address_d;
    logic [ADDR_W-1:0] read_address_q, read_address_d;
    logic [ADDR_W-1:0] slot_address_q, slot_address_d;
    logic [ADDR_W:0]   count_q, count_d;
    write_status_t     status_q, status_d;
    // Remembers whether the pending WRITE is an append (grows count) or an in-place update.
    logic              append_q, append_d;

    assign write_enable  = (state_q == S_CLEAR) || (state_q == S_WRITE);
    assign write_data    = (state_q == S_WRITE) ? new_node : '0;
    assign write_address = write_address_q;
    assign read_address  = read_address_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign status        = status_q;
    assign slot_address  = slot_address_q;
    assign count         = count_q;
    assign full          = (count_q == CNT_MAX);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            write_address_q <= '0;
            read_address_q  <= '0;
            slot_address_q  <= '0;
            count_q         <= '0;
            status_q        <= APPENDED;
            append_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_address_q <= write_address_d;
            read_address_q  <= read_address_d;
            slot_address_q  <= slot_address_d;
            count_q         <= count_d;
            status_q        <= status_d;
            append_q        <= append_d;
        end
    end

    // Next-state logic: command decode, clear sweep, 3-cycle-per-entry scan, final write.
    always_comb begin
        state_d         = state_q;
        write_address_d = write_address_q;
        read_address_d  = read_address_q;
        slot_address_d  = slot_address_q;
        count_d         = count_q;
        status_d        = status_q;
        append_d        = append_q;

        unique case (state_q)
            S_IDLE: begin
                // Clear takes priority; a simultaneous insert is dropped, not queued.
                if (clear) begin
                    state_d         = S_CLEAR;
                    write_address_d = '0;
                end else if (insert) begin
                    if (new_node.node_id == NODE_ID_EMPTY) begin
                        state_d  = S_DONE;
                        status_d = INVALID;
                    end else if (count_q == '0) begin
                        state_d         = S_WRITE;
                        write_address_d = '0;
                        append_d        = 1'b1;
                    end else begin
                        state_d        = S_SCAN_SET;
                        read_address_d = '0;
                    end
                end
            end

            S_CLEAR: begin
                if (write_address_q == LAST_ADDR) begin
                    count_d = '0;
                    state_d = S_DONE;
                end else begin
                    write_address_d = write_address_q + ADDR_ONE;
                end
            end

            // Two idle edges so the RAM's registered read data lines up with SCAN_READ.
            S_SCAN_SET:  state_d = S_SCAN_WAIT;
            S_SCAN_WAIT: state_d = S_SCAN_READ;

            S_SCAN_READ: begin
                if (read_node.node_id == new_node.node_id) begin
                    state_d         = S_WRITE;
                    write_address_d = read_address_q;
                    append_d        = 1'b0;
                end else if ({1'b0, read_address_q} == (count_q - CNT_ONE)) begin
                    if (full) begin
                        state_d  = S_DONE;
                        status_d = FULL;
                    end else begin
                        state_d         = S_WRITE;
                        write_address_d = count_q[ADDR_W-1:0];
                        append_d        = 1'b1;
                    end
                end else begin
                    state_d        = S_SCAN_SET;
                    read_address_d = read_address_q + ADDR_ONE;
                end
            end

            S_WRITE: begin
                slot_address_d = write_address_q;
                if (append_q) begin
                    count_d  = count_q + CNT_ONE;
                    status_d = APPENDED;
                end else begin
                    status_d = UPDATED;
                end
                state_d = S_DONE;
            end

            S_DONE:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_explored_writer.sv
// Scoreboard bench for explored_writer with a 2-edge-latency RAM model (MAX_NODES=8).
import pathfinding_pkg::*;

module tb_explored_writer;

    localparam int MAXN = 8;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          insert;
    node_info      new_node;
    node_info      read_node;
    logic          write_enable;
    logic [AW-1:0] write_address;
    node_info      write_data;
    logic [AW-1:0] read_address;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [AW-1:0] slot_address;
    logic [AW:0]   count;
    logic          full;

    explored_writer #(.MAX_NODES(MAXN), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .insert(insert),
        .new_node(new_node), .read_node(read_node),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .busy(busy), .done(done), .status(status),
        .slot_address(slot_address), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    // RAM model: registered address then registered data -> 2 edges of read latency.
    node_info      mem [0:(1<<AW)-1];
    logic [AW-1:0] ra_p;
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]         = '0;
            mem[i].node_id = 16'hFF00 + 16'(i);
            mem[i].cost    = 32'hDEAD0000 + 32'(i);
        end
        ra_p      = '0;
        read_node = '0;
    end
    always @(posedge clk) begin
        if (write_enable) mem[write_address] <= write_data;
        ra_p      <= read_address;
        read_node <= mem[ra_p];
    end

    typedef struct {
        logic [AW-1:0] addr;
        node_info      data;
    } exp_wr_t;

    exp_wr_t       exp_q[$];
    logic [15:0]   model_ids[$];
    logic [AW-1:0] model_slot;
    int            checks   = 0;
    int            failures = 0;

    // Every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d id=%0d (no write required)",
                         write_address, write_data.node_id);
            end else begin
                exp_wr_t e;
                e = exp_q.pop_front();
                if (write_address !== e.addr || write_data !== e.data) begin
                    failures++;
                    $display("FAIL write addr=%0d id=%0d cost=%0d required addr=%0d id=%0d cost=%0d",
                             write_address, write_data.node_id, write_data.cost,
                             e.addr, e.data.node_id, e.data.cost);
                end
            end
        end
    end

    function automatic node_info mk(input logic [15:0] id, input logic [31:0] cost);
        node_info n;
        n           = '0;
        n.node_id   = id;
        n.parent_id = id ^ 16'h1234;
        n.cost      = cost;
        n.heuristic = cost * 3;
        n.position  = '{x: id + 16'd1, y: id + 16'd2};
        return n;
    endfunction

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc <= limit) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // Drives a clear (optionally with a simultaneous insert) and pushes the sweep writes.
    task automatic do_clear(input bit with_insert, input node_info n, output int cyc, output bit ok);
        for (int i = 0; i < MAXN; i++) exp_q.push_back('{addr: AW'(i), data: '0});
        model_ids.delete();
        clear  = 1'b1;
        insert = with_insert;
        if (with_insert) new_node = n;
        @(negedge clk);
        clear  = 1'b0;
        insert = 1'b0;
        wait_done(60, cyc, ok);
        @(negedge clk);
    endtask

    // Drives one insert; the reference model decides the expected write, status and slot.
    task automatic do_insert(input node_info n, output logic [1:0] exp_st, output int cyc, output bit ok);
        int idx;
        idx = -1;
        for (int i = 0; i < model_ids.size(); i++) if (model_ids[i] == n.node_id) idx = i;
        if (n.node_id == 16'd0) begin
            exp_st = 2'b11;
        end else if (idx >= 0) begin
            exp_st     = 2'b01;
            model_slot = AW'(idx);
            exp_q.push_back('{addr: AW'(idx), data: n});
        end else if (model_ids.size() == MAXN) begin
            exp_st = 2'b10;
        end else begin
            exp_st     = 2'b00;
            model_slot = AW'(model_ids.size());
            exp_q.push_back('{addr: AW'(model_ids.size()), data: n});
            model_ids.push_back(n.node_id);
        end
        new_node = n;
        insert   = 1'b1;
        @(negedge clk);
        insert = 1'b0;
        wait_done(200, cyc, ok);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        clear    = 1'b0;
        insert   = 1'b0;
        new_node = '0;
        model_slot = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({write_enable, busy, done, status, slot_address, read_address, write_address, count, full} !== '0
            || write_data !== '0) begin
            failures++;
            $display("FAIL reset_values we=%b busy=%b done=%b st=%0d slot=%0d ra=%0d wa=%0d cnt=%0d required all 0",
                     write_enable, busy, done, status, slot_address, read_address, write_address, count);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clear();
        int cyc; bit ok;
        do_clear(1'b0, '0, cyc, ok);
        checks++;
        if (!ok || cyc != MAXN) begin
            failures++;
            $display("FAIL clear_latency cycles=%0d ok=%0d required %0d", cyc, ok, MAXN);
        end
        checks++;
        if (count !== '0 || busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL clear_end count=%0d busy=%b pending=%0d required 0 0 0", count, busy, exp_q.size());
        end
    endtask

    task automatic test_append();
        int cyc; bit ok; logic [1:0] es;
        do_insert(mk(16'd5, 32'd20), es, cyc, ok);
        checks++;
        if (!ok || cyc != 1) begin
            failures++;
            $display("FAIL append_latency cycles=%0d ok=%0d required 1", cyc, ok);
        end
        checks++;
        if (status !== 2'b00 || slot_address !== '0 || count !== 5'd1 || es !== 2'b00) begin
            failures++;
            $display("FAIL append_result st=%0d slot=%0d cnt=%0d required st=0 slot=0 cnt=1",
                     status, slot_address, count);
        end
    endtask

    task automatic test_update();
        int cyc; bit ok; logic [1:0] es;
        do_insert(mk(16'd9, 32'd30), es, cyc, ok);
        checks++;
        if (!ok || status !== 2'b00 || slot_address !== AW'(1) || count !== 5'd2) begin
            failures++;
            $display("FAIL append_second st=%0d slot=%0d cnt=%0d required st=0 slot=1 cnt=2",
                     status, slot_address, count);
        end
        do_insert(mk(16'd5, 32'd12), es, cyc, ok);
        checks++;
        if (!ok || status !== 2'b01 || slot_address !== '0 || count !== 5'd2) begin
            failures++;
            $display("FAIL update_result st=%0d slot=%0d cnt=%0d required st=1 slot=0 cnt=2",
                     status, slot_address, count);
        end
    endtask

    task automatic test_full();
        int cyc; bit ok; logic [1:0] es;
        do_clear(1'b0, '0, cyc, ok);
        for (int i = 0; i < MAXN; i++) begin
            do_insert(mk(16'(101 + i), 32'(200 + i)), es, cyc, ok);
            checks++;
            if (!ok || status !== 2'b00 || slot_address !== AW'(i) || count !== 5'(i + 1)) begin
                failures++;
                $display("FAIL fill_%0d st=%0d slot=%0d cnt=%0d required st=0 slot=%0d cnt=%0d",
                         i, status, slot_address, count, i, i + 1);
            end
        end
        do_insert(mk(16'd40, 32'd7), es, cyc, ok);
        checks++;
        if (!ok || status !== 2'b10 || full !== 1'b1 || count !== 5'd8 || slot_address !== AW'(7)) begin
            failures++;
            $display("FAIL full_reject st=%0d full=%b cnt=%0d slot=%0d required st=2 full=1 cnt=8 slot=7",
                     status, full, count, slot_address);
        end
        do_insert(mk(16'd104, 32'd99), es, cyc, ok);
        checks++;
        if (!ok || status !== 2'b01 || slot_address !== AW'(3) || count !== 5'd8) begin
            failures++;
            $display("FAIL full_update st=%0d slot=%0d cnt=%0d required st=1 slot=3 cnt=8",
                     status, slot_address, count);
        end
    endtask

    task automatic test_invalid_and_priority();
        int cyc; bit ok; logic [1:0] es;
        do_insert(mk(16'd0, 32'd1), es, cyc, ok);
        checks++;
        if (!ok || cyc > 2 || status !== 2'b11 || count !== 5'd8) begin
            failures++;
            $display("FAIL invalid_id cycles=%0d st=%0d cnt=%0d required cycles<=2 st=3 cnt=8",
                     cyc, status, count);
        end
        do_clear(1'b1, mk(16'd77, 32'd5), cyc, ok);
        checks++;
        if (!ok || cyc != MAXN || count !== '0) begin
            failures++;
            $display("FAIL clear_wins cycles=%0d cnt=%0d required cycles=%0d cnt=0", cyc, count, MAXN);
        end
        // An insert arriving mid-clear must be ignored as well.
        for (int i = 0; i < MAXN; i++) exp_q.push_back('{addr: AW'(i), data: '0});
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        new_node = mk(16'd88, 32'd3);
        insert   = 1'b1;
        @(negedge clk);
        insert = 1'b0;
        wait_done(60, cyc, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b0 || count !== '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL busy_ignore ok=%0d busy=%b cnt=%0d pending=%0d required 1 0 0 0",
                     ok, busy, count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_clear();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: AW'(i), data: '0});
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (write_enable === 1'b1 && write_address === AW'(3)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reach_addr3 write_address=%0d required 3", write_address);
        end
        #1 reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({write_enable, busy, done, status, slot_address, read_address, write_address, count} !== '0
            || write_data !== '0) begin
            failures++;
            $display("FAIL mid_reset we=%b busy=%b wa=%0d cnt=%0d st=%0d slot=%0d required all 0",
                     write_enable, busy, write_address, count, status, slot_address);
        end
        reset_n = 1'b1;
        model_ids.delete();
        model_slot = '0;
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || count !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_reset pending=%0d cnt=%0d busy=%b required 0 0 0", exp_q.size(), count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_append();
        test_update();
        test_full();
        test_invalid_and_priority();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
